// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   state_t        : loader FSM state encoding
//   MEM_SIZE_WORD  : MemSize code for a 32-bit access
//   MEM_RW_WRITE   : MemRW code for a write
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_COLLECT = 3'd3,
        ST_WRITE   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
    localparam logic       MEM_RW_WRITE  = 1'b0;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream and memory-write signals of the program loader.
//   RxData/RxValid/RxReady : incoming length-prefixed byte stream
//   MemAddr/MemData/MemMOV/MemRW/MemSize/MOC : memory write handshake
// modport master : the loader (accepts bytes, issues memory writes)
// modport slave  : the environment (byte source and memory)
interface program_loader_if;

    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;
    logic        MOC;
    logic [31:0] MemAddr;
    logic [31:0] MemData;
    logic        MemMOV;
    logic        MemRW;
    logic [1:0]  MemSize;

    modport master (
        input  RxData, RxValid, MOC,
        output RxReady, MemAddr, MemData, MemMOV, MemRW, MemSize
    );

    modport slave (
        output RxData, RxValid, MOC,
        input  RxReady, MemAddr, MemData, MemMOV, MemRW, MemSize
    );

endinterface

// File: rtl/loader_word_packer.sv
// Packs bytes into a big-endian 32-bit word, first byte in bits [31:24].
//   clk_sys   : clock
//   rst_b     : asynchronous reset, active-low
//   clear     : empty the word and restart at lane 0
//   byte_en   : insert byte_in at the current lane
//   byte_in   : byte to insert
//   word      : packed word; lanes not yet written read as zero
//   word_full : the byte being inserted this cycle completes the word
module loader_word_packer (
    input  logic        clk_sys,
    input  logic        rst_b,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0] lane;

    // Zero-fill of a short final word comes for free: the word is cleared
    // before each new word and only written lanes change.
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            word <= '0;
            lane <= '0;
        end else if (clear) begin
            word <= '0;
            lane <= '0;
        end else if (byte_en) begin
            case (lane)
                2'd0:    word[31:24] <= byte_in;
                2'd1:    word[23:16] <= byte_in;
                2'd2:    word[15:8]  <= byte_in;
                default: word[7:0]   <= byte_in;
            endcase
            lane <= lane + 2'd1;
        end
    end

    assign word_full = byte_en && (lane == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader. Takes a 16-bit big-endian length followed by
// that many image bytes, writes them as 32-bit words from address 0 and
// keeps the CPU in clear until the whole image is in memory.
//   CLK     : clock
//   CLR     : asynchronous reset, active-low
//   Start   : single-cycle pulse beginning a load
//   bus     : byte stream and memory write handshake (master side)
//   CpuHold : 1 keeps the CPU in clear
//   Done    : load completed (held until next Start)
//   Error   : load aborted (held until next Start)
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | after reset, waiting for Start
// ST_LEN_HI  | accepting length byte [15:8]
// ST_LEN_LO  | accepting length byte [7:0], then range-check
// ST_COLLECT | accepting image bytes into the packer
// ST_WRITE   | MemMOV high, waiting for MOC or timeout
// ST_DONE    | image written, CPU released
// ST_ERR     | bad length or memory timeout, CPU held
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 256,
    parameter int unsigned MOC_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             Start,
    program_loader_if.master bus,
    output logic             CpuHold,
    output logic             Done,
    output logic             Error
);

    localparam int unsigned      TMO_W    = $clog2(MOC_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MOC_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        len_hi;
    logic [15:0]       rem;
    logic [31:0]       addr;
    logic [TMO_W-1:0]  tmo;

    logic              rx_ready;
    logic              mov;
    logic              hold;
    logic              done_flag;
    logic              err_flag;
    logic              accept;
    logic              start_load;
    logic              write_ok;
    logic [15:0]       len_in;
    logic              pk_clear;
    logic              pk_byte_en;
    logic              pk_full;
    logic [31:0]       pk_word;

    assign accept     = bus.RxValid && rx_ready;
    assign start_load = Start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign write_ok   = (state == ST_WRITE) && bus.MOC;
    assign len_in     = {len_hi, bus.RxData};
    assign pk_clear   = start_load || write_ok;
    assign pk_byte_en = accept && (state == ST_COLLECT);

    loader_word_packer u_packer (
        .clk_sys   (CLK),
        .rst_b     (CLR),
        .clear     (pk_clear),
        .byte_en   (pk_byte_en),
        .byte_in   (bus.RxData),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state  <= ST_IDLE;
            len_hi <= '0;
            rem    <= '0;
            addr   <= '0;
            tmo    <= '0;
        end else begin
            state <= state_nxt;
            if (start_load) begin
                len_hi <= '0;
                rem    <= '0;
                addr   <= '0;
                tmo    <= '0;
            end
            case (state)
                ST_LEN_HI: if (accept) len_hi <= bus.RxData;
                ST_LEN_LO: if (accept) rem <= len_in;
                ST_COLLECT: begin
                    if (accept) begin
                        rem <= rem - 16'd1;
                        tmo <= '0;
                    end
                end
                ST_WRITE: begin
                    if (bus.MOC) begin
                        addr <= addr + 32'd4;
                        tmo  <= '0;
                    end else begin
                        tmo  <= tmo + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        mov       = 1'b0;
        hold      = 1'b1;
        done_flag = 1'b0;
        err_flag  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                rx_ready = 1'b1;
                if (accept) state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                rx_ready = 1'b1;
                // Range check uses the incoming low byte so the decision
                // lands in the cycle right after the length completes.
                if (accept) begin
                    if (len_in == 16'd0)
                        state_nxt = ST_DONE;
                    else if (32'(len_in) > MEM_BYTES)
                        state_nxt = ST_ERR;
                    else
                        state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                rx_ready = 1'b1;
                if (accept && (pk_full || rem == 16'd1)) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                mov = 1'b1;
                // MOC is tested first so it wins over a coincident timeout.
                if (bus.MOC)
                    state_nxt = (rem != 16'd0) ? ST_COLLECT : ST_DONE;
                else if (tmo == TMO_LAST)
                    state_nxt = ST_ERR;
            end
            ST_DONE: begin
                hold      = 1'b0;
                done_flag = 1'b1;
                if (Start) state_nxt = ST_LEN_HI;
            end
            ST_ERR: begin
                err_flag = 1'b1;
                if (Start) state_nxt = ST_LEN_HI;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.RxReady = rx_ready;
    assign bus.MemMOV  = mov;
    assign bus.MemRW   = MEM_RW_WRITE;
    assign bus.MemSize = MEM_SIZE_WORD;
    assign bus.MemAddr = addr;
    assign bus.MemData = pk_word;
    assign CpuHold     = hold;
    assign Done        = done_flag;
    assign Error       = err_flag;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic CLK;
    logic CLR;
    logic Start;
    logic CpuHold;
    logic Done;
    logic Error;

    program_loader_if bus ();

    program_loader #(
        .MEM_BYTES   (256),
        .MOC_TIMEOUT (15)
    ) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .Start   (Start),
        .bus     (bus),
        .CpuHold (CpuHold),
        .Done    (Done),
        .Error   (Error)
    );

    int   checks    = 0;
    int   errors    = 0;
    int   mov_count = 0;
    logic mov_prev  = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Counts MOV transactions (rising edges of MemMOV seen at negedge).
    always @(negedge CLK) begin
        if (bus.MemMOV === 1'b1 && mov_prev !== 1'b1) mov_count++;
        mov_prev = bus.MemMOV;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.RxData  = b;
        bus.RxValid = 1'b1;
        while (bus.RxReady !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("rx_ready_wait", {31'b0, bus.RxReady}, 32'd1);
        tick();
        bus.RxValid = 1'b0;
    endtask

    // Memory responder: MOC raised on the 2nd cycle of MemMOV.
    task automatic service_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (bus.MemMOV !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_mov"},     {31'b0, bus.MemMOV}, 32'd1);
        check({tag, "_addr"},    bus.MemAddr, a);
        check({tag, "_data"},    bus.MemData, d);
        check({tag, "_rw_size"}, {29'b0, bus.MemRW, bus.MemSize}, 32'h0000_0002);
        check({tag, "_noready"}, {31'b0, bus.RxReady}, 32'd0);
        tick();
        check({tag, "_stable"},  bus.MemAddr ^ bus.MemData, a ^ d);
        check({tag, "_mov2"},    {31'b0, bus.MemMOV}, 32'd1);
        bus.MOC = 1'b1;
        tick();
        bus.MOC = 1'b0;
        check({tag, "_movfall"}, {31'b0, bus.MemMOV}, 32'd0);
    endtask

    initial begin
        int m0;
        int n;

        CLR         = 1'b0;
        Start       = 1'b0;
        bus.RxData  = 8'h00;
        bus.RxValid = 1'b0;
        bus.MOC     = 1'b0;
        #12;

        // Reset values
        check("rst_hold",  {31'b0, CpuHold},      32'd1);
        check("rst_ready", {31'b0, bus.RxReady},  32'd0);
        check("rst_mov",   {31'b0, bus.MemMOV},   32'd0);
        check("rst_rw",    {31'b0, bus.MemRW},    32'd0);
        check("rst_size",  {30'b0, bus.MemSize},  32'd2);
        check("rst_addr",  bus.MemAddr,           32'd0);
        check("rst_data",  bus.MemData,           32'd0);
        check("rst_done",  {31'b0, Done},         32'd0);
        check("rst_error", {31'b0, Error},        32'd0);
        CLR = 1'b1;
        tick();
        check("idle_ready", {31'b0, bus.RxReady}, 32'd0);

        // Two full words, LEN=8
        pulse_start();
        check("t1_lenhi_ready", {31'b0, bus.RxReady}, 32'd1);
        send_byte(8'h00); send_byte(8'h08);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        check("t1_w0_latency", {31'b0, bus.MemMOV}, 32'd1);
        service_write("t1_w0", 32'd0, 32'hDEADBEEF);
        check("t1_not_done", {31'b0, Done}, 32'd0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        service_write("t1_w1", 32'd4, 32'h01020304);
        check("t1_done",  {31'b0, Done},    32'd1);
        check("t1_hold",  {31'b0, CpuHold}, 32'd0);
        check("t1_error", {31'b0, Error},   32'd0);
        check("t1_movs",  mov_count,        32'd2);

        // LEN=5: partial final word, byte held through WRITE
        m0 = mov_count;
        pulse_start();
        check("t2_done_clr", {31'b0, Done},    32'd0);
        check("t2_hold",     {31'b0, CpuHold}, 32'd1);
        check("t2_addr_clr", bus.MemAddr,      32'd0);
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        bus.RxData  = 8'h55;
        bus.RxValid = 1'b1;
        service_write("t2_w0", 32'd0, 32'h11223344);
        check("t2_ready_again", {31'b0, bus.RxReady}, 32'd1);
        check("t2_data_clr",    bus.MemData,          32'd0);
        check("t2_addr4",       bus.MemAddr,          32'd4);
        tick();
        bus.RxValid = 1'b0;
        check("t2_w1_latency", {31'b0, bus.MemMOV}, 32'd1);
        service_write("t2_w1", 32'd4, 32'h55000000);
        check("t2_done", {31'b0, Done}, 32'd1);
        check("t2_movs", mov_count - m0, 32'd2);

        // LEN=0
        m0 = mov_count;
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        check("t3_done", {31'b0, Done},    32'd1);
        check("t3_hold", {31'b0, CpuHold}, 32'd0);
        tick();
        check("t3_movs", mov_count - m0, 32'd0);

        // LEN=257: too long
        m0 = mov_count;
        pulse_start();
        send_byte(8'h01); send_byte(8'h01);
        check("t4_error", {31'b0, Error},       32'd1);
        check("t4_hold",  {31'b0, CpuHold},     32'd1);
        check("t4_ready", {31'b0, bus.RxReady}, 32'd0);
        check("t4_done",  {31'b0, Done},        32'd0);
        tick();
        check("t4_movs",  mov_count - m0,       32'd0);
        pulse_start();
        check("t4_err_clr", {31'b0, Error}, 32'd0);
        send_byte(8'h00); send_byte(8'h04);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
        service_write("t4_w0", 32'd0, 32'hCAFEBABE);
        check("t4_reload_done", {31'b0, Done}, 32'd1);

        // MOC never returned: timeout after 15 cycles in WRITE
        m0 = mov_count;
        pulse_start();
        send_byte(8'h00); send_byte(8'h08);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        n = 0;
        while (bus.MemMOV === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("t5_mov_cycles", n, 32'd15);
        check("t5_error",      {31'b0, Error},   32'd1);
        check("t5_hold",       {31'b0, CpuHold}, 32'd1);
        check("t5_done",       {31'b0, Done},    32'd0);
        bus.RxValid = 1'b1;
        bus.RxData  = 8'h77;
        tick();
        check("t5_ready", {31'b0, bus.RxReady}, 32'd0);
        bus.RxValid = 1'b0;
        check("t5_movs",  mov_count - m0,       32'd1);

        // MOC on the last timeout cycle: MOC wins
        pulse_start();
        check("t6_err_clr", {31'b0, Error}, 32'd0);
        send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
        check("t6_mov", {31'b0, bus.MemMOV}, 32'd1);
        repeat (14) tick();
        check("t6_mov_late", {31'b0, bus.MemMOV}, 32'd1);
        bus.MOC = 1'b1;
        tick();
        bus.MOC = 1'b0;
        check("t6_done",  {31'b0, Done},       32'd1);
        check("t6_error", {31'b0, Error},      32'd0);
        check("t6_mov0",  {31'b0, bus.MemMOV}, 32'd0);

        // LEN=256 accepted; reset while MemMOV=1
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        check("t7_len256_ready", {31'b0, bus.RxReady}, 32'd1);
        check("t7_len256_error", {31'b0, Error},       32'd0);
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        check("t7_mov", {31'b0, bus.MemMOV}, 32'd1);
        #2 CLR = 1'b0;
        #1;
        check("t7_rst_mov",   {31'b0, bus.MemMOV},  32'd0);
        check("t7_rst_ready", {31'b0, bus.RxReady}, 32'd0);
        check("t7_rst_done",  {31'b0, Done},        32'd0);
        check("t7_rst_error", {31'b0, Error},       32'd0);
        check("t7_rst_hold",  {31'b0, CpuHold},     32'd1);
        check("t7_rst_addr",  bus.MemAddr,          32'd0);
        #2 CLR = 1'b1;
        tick();
        m0 = mov_count;
        bus.RxValid = 1'b1;
        bus.RxData  = 8'h00;
        repeat (3) tick();
        check("t7_idle_ready", {31'b0, bus.RxReady}, 32'd0);
        check("t7_idle_hold",  {31'b0, CpuHold},     32'd1);
        check("t7_idle_movs",  mov_count - m0,       32'd0);
        bus.RxValid = 1'b0;
        pulse_start();
        send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
        service_write("t7_w0", 32'd0, 32'h01234567);
        check("t7_done", {31'b0, Done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
